key_matrix_scan: RTL
====================

// Module: key_matrix_scan
// PURPOSE
// - Input-side counterpart to the LED matrix display driver: scans a GSxGS push-button matrix
//   column by column, reads the rows, debounces, and publishes a key bitmap plus a new-press event.
// - Sits beside the input stage under the top-level Input/Action/Display sequencer.
// - Uses the same enable/done handshake: start on e_scan_i, finish with a d_scan_o pulse.
// PARAMETERS
// - GS     8   matrix size (GS columns x GS rows); KW = $clog2(GS*GS)
// - SETTLE 15  extra cycles each column is driven before its rows are sampled (>=0)
// PORTS
// - clk_i        in   1        single clock; all logic on posedge
// - reset_i      in   1        synchronous, active-high reset
// - e_scan_i     in   1        enable: level-sensitive request for one full frame scan
// - row_i        in   GS       row sense lines, active-high (pressed = 1)
// - col_o        out  GS       column drive, one-hot active-high, 0 when idle
// - keys_o       out  GS*GS    debounced key map, bit [c*GS+r] = column c, row r
// - key_valid_o  out  1        1-cycle pulse: at least one key newly pressed this frame
// - key_code_o   out  KW       index c*GS+r of the lowest newly pressed key (held until next event)
// - d_scan_o     out  1        1-cycle done pulse at end of frame
// BEHAVIOUR
// - Reset (sync, any state): state=IDLE; col_o=0, keys_o=0, key_valid_o=0, key_code_o=0,
//   d_scan_o=0; raw frame and previous frame registers cleared; counters cleared.
// - FSM: IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: col_o=0; e_scan_i=1 sampled at edge t -> SCAN, col_o=1<<0 from t+1.
//   SCAN: column c is driven for SETTLE+1 cycles. On its last cycle, row_i is captured into raw[c*GS +: GS].
//     Then c increments and col_o shifts next cycle. After column GS-1 is sampled -> DONE.
//   DONE: exactly one cycle; d_scan_o=1; col_o=0; then IDLE.
//     If e_scan_i is still 1 in IDLE, the next frame starts (back-to-back frames permitted).
// - Latency: e_scan_i seen at edge t -> d_scan_o high in cycle t+1+GS*(SETTLE+1).
// - e_scan_i dropping mid-SCAN does not abort; the frame completes.
// - Debounce (applied at DONE, per bit): stable = ~(raw ^ prev).
//   keys_o <= (keys_o & ~stable) | (raw & stable); prev <= raw.
//   A key changes only after two consecutive identical frames; a single-frame glitch is ignored.
// - Event (same cycle as d_scan_o): new = keys_next & ~keys_o.
//   If new != 0: key_valid_o=1 and key_code_o = index of the lowest set bit of new.
//   Otherwise key_valid_o=0 and key_code_o keeps its value.
// - Simultaneous presses: all bits appear in keys_o; only the lowest index is reported as code.
// - Ghosting is not resolved; keys_o reflects the raw sensed matrix.
// - Reset mid-scan: immediate return to IDLE, col_o=0 next cycle, no d_scan_o.
// CONFIGURATION
// - KEY_RELEASE_EN defined: adds output key_rel_o (1), a 1-cycle pulse with d_scan_o when
//   rel = keys_o & ~keys_next != 0. Reset value 0. key_code_o then reports the lowest
//   released index only if no new press occurred in that frame (a press has priority).
// - Not defined: key_rel_o absent; releases only clear keys_o bits silently.
// TESTING
// - Reset: reset_i=1 2 cycles -> all outputs 0, col_o=0; e_scan_i=1 -> col_o=8'h01 next cycle.
// - Timing, GS=8, SETTLE=3: e_scan_i pulse at edge t -> col_o steps 01,02,..,80 every 4 cycles;
//   d_scan_o=1 only in cycle t+33.
// - Press c=2,r=5 for 2 frames -> frame1: keys_o=0, no valid; frame2: keys_o[21]=1,
//   key_valid_o=1, key_code_o=21; frame3 held -> no valid.
// - Glitch: row_i[1]=1 only while col 0 is driven, for one frame -> keys_o stays 0, no valid.
// - Two keys (idx 40 and 3) pressed together for 2 frames -> keys_o[40]=keys_o[3]=1, code=3.
// - reset_i=1 during column 4 of a frame with keys held -> IDLE, col_o=0, keys_o=0, no d_scan_o.
// - KEY_RELEASE_EN: release idx 21 for 2 frames -> key_rel_o=1, key_code_o=21, keys_o[21]=0.

Source files
------------

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - column-scanned push-button matrix reader with frame-to-frame debounce
// Optional KEY_RELEASE_EN adds key_rel_o and reports released keys in key_code_o.
module key_matrix_scan #(
  parameter int GS     = 8,
  parameter int SETTLE = 15,
  localparam int KW    = $clog2(GS*GS)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             e_scan_i,
  input  logic [GS-1:0]    row_i,
  output logic [GS-1:0]    col_o,
  output logic [GS*GS-1:0] keys_o,
  output logic             key_valid_o,
  output logic [KW-1:0]    key_code_o,
  output logic             d_scan_o
`ifdef KEY_RELEASE_EN
  ,
  output logic             key_rel_o
`endif
);

  localparam int CW = (GS > 1) ? $clog2(GS) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     col_idx;
  logic [SW-1:0]     settle_cnt;
  logic [GS*GS-1:0]  raw, prev, raw_fin, stable, keys_next, new_keys, rel_keys;
  logic              last_sample, last_col;

  function automatic logic [KW-1:0] lowest(input logic [GS*GS-1:0] v);
    lowest = '0;
    for (int i = GS*GS-1; i >= 0; i--) begin
      if (v[i]) lowest = KW'(i);
    end
  endfunction

  assign last_sample = (state == SCAN) && (settle_cnt == SW'(SETTLE));
  assign last_col    = (col_idx == CW'(GS-1));

  always_comb begin
    state_next = state;
    col_o      = '0;
    d_scan_o   = 1'b0;
    case (state)
      IDLE: if (e_scan_i) state_next = SCAN;
      SCAN: begin
        col_o[col_idx] = 1'b1;
        if (last_sample && last_col) state_next = DONE;
      end
      DONE: begin
        d_scan_o   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final column is folded in combinationally so the debounced map and
  // the event are already registered by the time d_scan_o is high.
  always_comb begin
    raw_fin = raw;
    raw_fin[col_idx*GS +: GS] = row_i;
  end

  assign stable    = ~(raw_fin ^ prev);
  assign keys_next = (keys_o & ~stable) | (raw_fin & stable);
  assign new_keys  = keys_next & ~keys_o;
  assign rel_keys  = keys_o & ~keys_next;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      col_idx     <= '0;
      settle_cnt  <= '0;
      raw         <= '0;
      prev        <= '0;
      keys_o      <= '0;
      key_valid_o <= 1'b0;
      key_code_o  <= '0;
`ifdef KEY_RELEASE_EN
      key_rel_o   <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      key_valid_o <= 1'b0;
`ifdef KEY_RELEASE_EN
      key_rel_o   <= 1'b0;
`endif
      if (state != SCAN) begin
        col_idx    <= '0;
        settle_cnt <= '0;
      end else if (!last_sample) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else begin
        raw        <= raw_fin;
        settle_cnt <= '0;
        col_idx    <= last_col ? '0 : col_idx + 1'b1;
        if (last_col) begin
          prev   <= raw_fin;
          keys_o <= keys_next;
          if (|new_keys) begin
            key_valid_o <= 1'b1;
            key_code_o  <= lowest(new_keys);
          end
`ifdef KEY_RELEASE_EN
          else if (|rel_keys) begin
            key_code_o <= lowest(rel_keys);
          end
          key_rel_o <= |rel_keys;
`endif
        end
      end
    end
  end

`ifndef KEY_RELEASE_EN
  logic unused_rel;
  assign unused_rel = ^rel_keys;
`endif

endmodule
